// File: rtl/useq_next_addr_if.sv
// useq_next_addr_if: sequencing bundle between microcode ROM / micro-PC register and the next-address unit
interface useq_next_addr_if #(
  parameter int UPC_W       = 5,
  parameter int STACK_DEPTH = 4,
  parameter int CNT_W       = 8
);
  logic                               start;
  logic [UPC_W-1:0]                   upc;
  logic [2:0]                         seq_op;
  logic [UPC_W-1:0]                   seq_addr;
  logic [CNT_W-1:0]                   cnt_imm;
  logic [3:0]                         cond;
  logic [1:0]                         cond_sel;
  logic                               cond_inv;
  logic                               load_incr;
  logic [UPC_W-1:0]                   upc_next;
  logic                               busy;
  logic                               done;
  logic                               err;
  logic [$clog2(STACK_DEPTH+1)-1:0]   sp;
  modport master (
    output start, upc, seq_op, seq_addr, cnt_imm, cond, cond_sel, cond_inv,
    input  load_incr, upc_next, busy, done, err, sp
  );
  modport slave (
    input  start, upc, seq_op, seq_addr, cnt_imm, cond, cond_sel, cond_inv,
    output load_incr, upc_next, busy, done, err, sp
  );
endinterface

// File: rtl/useq_next_addr.sv
// useq_next_addr: micro-sequencer next-address unit with return stack; define USEQ_LOOP_EN
// to implement the LDCNT/LOOP counter (otherwise those opcodes act as CONT)
module useq_next_addr #(
  parameter int UPC_W       = 5,
  parameter int STACK_DEPTH = 4,
  parameter int CNT_W       = 8
) (
  input logic               clk,
  input logic               reset,
  useq_next_addr_if.slave   bus
);
  localparam int SP_W  = $clog2(STACK_DEPTH+1);
  localparam int IDX_W = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, HALTED, ERROR} state_t;
  typedef enum logic [2:0] {CONT, JMP, JCC, CALL, RET, LDCNT, LOOP, HALT} op_t;
  state_t           state_q, state_d;
  logic [SP_W-1:0]  sp_q, sp_d, sp_m1;
  logic             err_q, err_d, push, c, loop_take;
  logic [UPC_W-1:0] stack_q [2**IDX_W];
  op_t              op;
  assign op    = op_t'(bus.seq_op);
  assign c     = bus.cond[bus.cond_sel] ^ bus.cond_inv;
  assign sp_m1 = sp_q - SP_W'(1);
`ifdef USEQ_LOOP_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign loop_take = cnt_q != '0;
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == RUN && op == LDCNT) cnt_d = bus.cnt_imm;
    if (state_q == RUN && op == LOOP && loop_take) cnt_d = cnt_q - CNT_W'(1);
  end
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
`else
  logic unused_cnt_imm;
  assign unused_cnt_imm = ^bus.cnt_imm;
  assign loop_take = 1'b0;
`endif
  always_comb begin
    state_d       = state_q;
    sp_d          = sp_q;
    err_d         = err_q;
    push          = 1'b0;
    bus.load_incr = 1'b1;
    bus.upc_next  = bus.upc;
    case (state_q)
      IDLE: begin
        bus.upc_next = '0;
        state_d      = bus.start ? RUN : IDLE;
      end
      RUN: case (op)
        JMP:  bus.upc_next = bus.seq_addr;
        JCC: begin
          bus.load_incr = c;
          bus.upc_next  = bus.seq_addr;
        end
        CALL: begin
          if (sp_q == SP_W'(STACK_DEPTH)) begin
            err_d   = 1'b1;
            state_d = ERROR;
          end else begin
            push         = 1'b1;
            sp_d         = sp_q + SP_W'(1);
            bus.upc_next = bus.seq_addr;
          end
        end
        RET: begin
          if (sp_q == '0) begin
            err_d   = 1'b1;
            state_d = ERROR;
          end else begin
            sp_d         = sp_m1;
            bus.upc_next = stack_q[sp_m1[IDX_W-1:0]];
          end
        end
        LOOP: begin
          bus.load_incr = loop_take;
          bus.upc_next  = bus.seq_addr;
        end
        HALT: state_d = HALTED;
        default: bus.load_incr = 1'b0;
      endcase
      HALTED: state_d = bus.start ? IDLE : HALTED;
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sp_q    <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < 2**IDX_W; i++) stack_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
      if (push) stack_q[sp_q[IDX_W-1:0]] <= bus.upc + UPC_W'(1);
    end
  end
  assign bus.busy = state_q == RUN;
  assign bus.done = state_q == HALTED;
  assign bus.err  = err_q;
  assign bus.sp   = sp_q;
endmodule
